// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = datapath side driving register indices, slave = hazard_ctrl.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             LoadE;
  logic [4:0]       RdM, RdW;
  logic             PCSrcE;
  logic             MemReqM;
  logic             dmem_ready;
  logic             perf_clr;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, RegWriteM, RegWriteW,
           LoadE, RdM, RdW, PCSrcE, MemReqM, dmem_ready, perf_clr,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, RegWriteM, RegWriteW,
           LoadE, RdM, RdW, PCSrcE, MemReqM, dmem_ready, perf_clr,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall, branch flush,
// data-memory wait/timeout FSM and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       mem_stall;
  logic       lw_stall;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;

  // RegWriteE is part of the pipeline bundle but no hazard depends on it.
  logic unused_regwrite_e;
  assign unused_regwrite_e = bus.RegWriteE;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (bus.RegWriteM && bus.RdM == rs && rs != 5'd0)
      return 2'b10;
    else if (bus.RegWriteW && bus.RdW == rs && rs != 5'd0)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(bus.Rs1E);
    fwd_b = fwd_sel(bus.Rs2E);
    lw_stall = bus.LoadE && bus.RdE != 5'd0 &&
               (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D) && !bus.PCSrcE;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.MemReqM && !bus.dmem_ready) begin
          mem_stall  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = RUN;
        end else begin
          mem_stall  = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WC_W'(TIMEOUT - 1))
            state_d = ERR;
        end
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // A memory wait freezes every stage, so any branch flush waits for release.
  always_comb begin
    stall_f = lw_stall;
    stall_d = lw_stall;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = bus.PCSrcE;
    flush_e = lw_stall || bus.PCSrcE;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_f && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_d && !(&flush_cnt_q))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ForwardAE    = fwd_a;
  assign bus.ForwardBE    = fwd_b;
  assign bus.StallF       = stall_f;
  assign bus.StallD       = stall_d;
  assign bus.StallE       = stall_e;
  assign bus.StallM       = stall_m;
  assign bus.FlushD       = flush_d;
  assign bus.FlushE       = flush_e;
  assign bus.FlushW       = flush_w;
  assign bus.mem_err      = (state_q == ERR);
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;
endmodule
